// File: rtl/atm_pin_entry_pkg.sv
// Shared definitions for the ATM keypad PIN-entry front end.
package atm_entry_pkg;

    typedef enum logic [2:0] {
        StAcc,
        StPin,
        StAuth,
        StSession,
        StLock
    } state_e;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam int unsigned PIN_DIGITS = 4;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad / authenticator / ATM-side signals of the PIN-entry block.
interface atm_pin_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_done;
    logic        auth_ok;
    logic        session_end;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        auth_req;
    logic        session_active;
    logic        locked;
    logic [1:0]  attempts_left;

    // The PIN-entry block itself.
    modport slave (
        input  key_valid, key_code, auth_done, auth_ok, session_end,
        output acc_num, pin, auth_req, session_active, locked, attempts_left
    );

    // Whatever drives the keypad and authenticator side.
    modport master (
        output key_valid, key_code, auth_done, auth_ok, session_end,
        input  acc_num, pin, auth_req, session_active, locked, attempts_left
    );
endinterface

// File: rtl/atm_pin_entry_cycle_timer.sv
// Clear/enable up-counter with a terminal-count compare; saturates at all-ones.
module cycle_timer #(
    parameter int unsigned Width    = 8,
    parameter int unsigned Terminal = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [Width-1:0] TermCount = Width'(Terminal);

    logic [Width-1:0] count_q, count_d;

    // Next count: clear wins over enable, hold once saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == TermCount);

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad front end: collects account digit and 4-digit BCD PIN, requests
// authentication, holds credentials for the session and enforces lockout.
module atm_pin_entry
    import atm_entry_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LOCK_CYCLES  = 1000,
    parameter int unsigned IDLE_TIMEOUT = 5000
) (
    input logic           clk,
    input logic           rst,
    atm_pin_entry_if.slave bus
);

    localparam int unsigned TimerMax   = (LOCK_CYCLES > IDLE_TIMEOUT) ? LOCK_CYCLES : IDLE_TIMEOUT;
    localparam int unsigned TimerWidth = $clog2(TimerMax + 1);
    localparam logic [1:0]  MaxAtt     = 2'(MAX_ATTEMPTS);
    localparam logic [2:0]  FullCount  = 3'(PIN_DIGITS);

    state_e      state_q, state_d;
    logic [3:0]  acc_q;
    logic [15:0] pin_q;
    logic [2:0]  count_q;
    logic [1:0]  attempts_q;
    logic        auth_req_q;

    logic digit_key, enter_key, clear_key, cancel_key;
    logic pin_accept, idle_expire, idle_done, lock_done, state_change;

    assign digit_key  = bus.key_valid && is_digit(bus.key_code);
    assign enter_key  = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign clear_key  = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign cancel_key = bus.key_valid && (bus.key_code == KEY_CANCEL);

    // A key that has an effect in PIN entry; ignored keys do not restart the idle timer.
    assign pin_accept = (state_q == StPin) &&
                        ((digit_key && (count_q < FullCount)) ||
                         (enter_key && (count_q == FullCount)) ||
                         clear_key || cancel_key);
    assign idle_expire  = (state_q == StPin) && idle_done && !pin_accept;
    assign state_change = (state_d != state_q);

    // Idle timer: terminal one cycle early so PIN lasts exactly IDLE_TIMEOUT silent cycles.
    cycle_timer #(
        .Width    (TimerWidth),
        .Terminal (IDLE_TIMEOUT - 1)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_change || pin_accept),
        .enable (state_q == StPin),
        .done   (idle_done)
    );

    cycle_timer #(
        .Width    (TimerWidth),
        .Terminal (LOCK_CYCLES - 1)
    ) u_lock_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_change),
        .enable (state_q == StLock),
        .done   (lock_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc: begin
                if (digit_key) state_d = StPin;
            end
            StPin: begin
                if (cancel_key || idle_expire) begin
                    state_d = StAcc;
                end else if (enter_key && (count_q == FullCount)) begin
                    state_d = StAuth;
                end
            end
            StAuth: begin
                if (bus.auth_done) begin
                    if (bus.auth_ok)              state_d = StSession;
                    else if (attempts_q > 2'd1)   state_d = StPin;
                    else                          state_d = StLock;
                end
            end
            StSession: begin
                if (bus.session_end) state_d = StAcc;
            end
            StLock: begin
                if (lock_done) state_d = StAcc;
            end
            default: state_d = StAcc;
        endcase
    end

    // Credential, digit-count and attempt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            pin_q      <= '0;
            count_q    <= '0;
            attempts_q <= MaxAtt;
            auth_req_q <= 1'b0;
        end else begin
            auth_req_q <= (state_d == StAuth) && (state_q != StAuth);
            unique case (state_q)
                StAcc: begin
                    if (digit_key) acc_q <= bus.key_code;
                end
                StPin: begin
                    if (cancel_key || idle_expire) begin
                        acc_q   <= '0;
                        pin_q   <= '0;
                        count_q <= '0;
                    end else if (clear_key) begin
                        pin_q   <= '0;
                        count_q <= '0;
                    end else if (digit_key && (count_q < FullCount)) begin
                        pin_q   <= {pin_q[11:0], bus.key_code};
                        count_q <= count_q + 3'd1;
                    end
                end
                StAuth: begin
                    if (bus.auth_done) begin
                        if (bus.auth_ok) begin
                            attempts_q <= MaxAtt;
                        end else if (attempts_q > 2'd1) begin
                            attempts_q <= attempts_q - 2'd1;
                            pin_q      <= '0;
                            count_q    <= '0;
                        end else begin
                            attempts_q <= '0;
                        end
                    end
                end
                StSession: begin
                    if (bus.session_end) begin
                        acc_q   <= '0;
                        pin_q   <= '0;
                        count_q <= '0;
                    end
                end
                StLock: begin
                    if (lock_done) begin
                        attempts_q <= MaxAtt;
                        acc_q      <= '0;
                        pin_q      <= '0;
                        count_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs, all from registers.
    always_comb begin
        bus.acc_num        = acc_q;
        bus.pin            = pin_q;
        bus.auth_req       = auth_req_q;
        bus.session_active = (state_q == StSession);
        bus.locked         = (state_q == StLock);
        bus.attempts_left  = attempts_q;
    end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Self-checking bench for atm_pin_entry against a behavioural reference model.
module tb_atm_pin_entry;

    localparam int unsigned MaxAtt  = 3;
    localparam int unsigned LockCyc = 1000;
    localparam int unsigned IdleTo  = 5000;

    localparam int ModeAcc  = 0;
    localparam int ModePin  = 1;
    localparam int ModeAuth = 2;
    localparam int ModeSess = 3;
    localparam int ModeLock = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    atm_pin_entry_if bus();

    atm_pin_entry #(
        .MAX_ATTEMPTS (MaxAtt),
        .LOCK_CYCLES  (LockCyc),
        .IDLE_TIMEOUT (IdleTo)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, account digit, queue of entered PIN digits, counters.
    int m_mode;
    int m_acc;
    int m_dig[$];
    int m_att;
    int m_idle;
    int m_lock;
    bit m_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pin();
        logic [15:0] p = '0;
        foreach (m_dig[i]) p = {p[11:0], 4'(m_dig[i])};
        return p;
    endfunction

    function automatic logic [31:0] model_outs();
        return {7'd0, 4'(m_acc), model_pin(), m_req, (m_mode == ModeSess),
                (m_mode == ModeLock), 2'(m_att)};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {7'd0, bus.acc_num, bus.pin, bus.auth_req, bus.session_active,
                bus.locked, bus.attempts_left};
    endfunction

    task automatic model_abandon();
        m_acc = 0;
        m_dig.delete();
        m_mode = ModeAcc;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit ad, input bit ao,
                              input bit se, input bit r);
        bit took;
        m_req = 0;
        if (r) begin
            model_abandon();
            m_att  = MaxAtt;
            m_idle = 0;
            m_lock = 0;
            return;
        end
        case (m_mode)
            ModeAcc: begin
                if (kv && kc <= 9) begin
                    m_acc  = kc;
                    m_mode = ModePin;
                    m_idle = 0;
                end
            end
            ModePin: begin
                took = kv && ((kc <= 9 && m_dig.size() < 4) || (kc == 10 && m_dig.size() == 4) ||
                              kc == 11 || kc == 12);
                if (took) begin
                    m_idle = 0;
                    if (kc <= 9) m_dig.push_back(kc);
                    else if (kc == 10) begin
                        m_mode = ModeAuth;
                        m_req  = 1;
                    end else if (kc == 11) m_dig.delete();
                    else model_abandon();
                end else begin
                    m_idle++;
                    if (m_idle >= IdleTo) model_abandon();
                end
            end
            ModeAuth: begin
                if (ad) begin
                    if (ao) begin
                        m_att  = MaxAtt;
                        m_mode = ModeSess;
                    end else if (m_att > 1) begin
                        m_att--;
                        m_dig.delete();
                        m_mode = ModePin;
                        m_idle = 0;
                    end else begin
                        m_att  = 0;
                        m_mode = ModeLock;
                        m_lock = 0;
                    end
                end
            end
            ModeSess: begin
                if (se) model_abandon();
            end
            default: begin
                m_lock++;
                if (m_lock >= LockCyc) begin
                    m_att = MaxAtt;
                    model_abandon();
                end
            end
        endcase
    endtask

    // One clock cycle: drive inputs, advance model, compare after the edge.
    task automatic cyc(input bit kv, input logic [3:0] kc, input bit ad, input bit ao,
                       input bit se, input bit r);
        bus.key_valid   = kv;
        bus.key_code    = kc;
        bus.auth_done   = ad;
        bus.auth_ok     = ao;
        bus.session_end = se;
        rst             = r;
        model_step(kv, int'(kc), ad, ao, se, r);
        @(posedge clk);
        #1;
        check("outs", dut_outs(), model_outs());
    endtask

    task automatic key(input logic [3:0] k);
        cyc(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic auth(input bit ok);
        cyc(1'b0, 4'h0, 1'b1, ok, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic enter_pin(input logic [3:0] a, input logic [15:0] p);
        key(a);
        for (int i = 3; i >= 0; i--) key(p[i*4 +: 4]);
        key(4'hA);
    endtask

    int lc;

    initial begin
        bus.key_valid = 0; bus.key_code = 0; bus.auth_done = 0;
        bus.auth_ok = 0; bus.session_end = 0;
        m_att = MaxAtt;
        do_reset();
        do_reset();
        check("reset_outs", dut_outs(), {7'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd3});

        // Normal login.
        enter_pin(4'd3, 16'h1234);
        check("login_req", 32'(bus.auth_req), 32'd1);
        check("login_pin", 32'(bus.pin), 32'h1234);
        check("login_acc", 32'(bus.acc_num), 32'd3);
        nop();
        check("req_one_cycle", 32'(bus.auth_req), 32'd0);
        auth(1'b1);
        check("session", 32'(bus.session_active), 32'd1);
        key(4'd7);
        check("session_frozen", 32'(bus.pin), 32'h1234);
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("session_end_pin", 32'(bus.pin), 32'd0);
        check("session_end_acc", 32'(bus.acc_num), 32'd0);

        // Editing, short ENTER, and a failure followed by CANCEL.
        key(4'd6); key(4'd5); key(4'd9); key(4'd8); key(4'hA);
        check("short_enter", 32'(bus.auth_req), 32'd0);
        key(4'hB); key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("edit_pin", 32'(bus.pin), 32'h1234);
        key(4'hA);
        check("edit_req", 32'(bus.auth_req), 32'd1);
        auth(1'b0);
        check("att_after_fail", 32'(bus.attempts_left), 32'd2);
        key(4'hC);
        key(4'd4);
        check("cancel_keeps_att", 32'(bus.attempts_left), 32'd2);

        // Two more failures lead to lockout.
        for (int i = 0; i < 4; i++) key(4'd1);
        key(4'hA);
        auth(1'b0);
        check("att_1", 32'(bus.attempts_left), 32'd1);
        for (int i = 0; i < 4; i++) key(4'd2);
        key(4'hA);
        auth(1'b0);
        check("att_0", 32'(bus.attempts_left), 32'd0);
        lc = 0;
        for (int i = 0; i < LockCyc + 100 && bus.locked; i++) begin
            lc++;
            cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("lock_len", 32'(lc), 32'(LockCyc));
        check("post_lock_att", 32'(bus.attempts_left), 32'd3);
        check("post_lock_acc", 32'(bus.acc_num), 32'd0);

        // Idle timeout from last key.
        key(4'd7); key(4'd1);
        for (int i = 0; i < IdleTo - 1; i++) nop();
        check("idle_before", 32'(bus.acc_num), 32'd7);
        nop();
        check("idle_acc", 32'(bus.acc_num), 32'd0);
        check("idle_pin", 32'(bus.pin), 32'd0);

        // Key at relative cycle 4999 after PIN entry restarts the timer.
        key(4'd7);
        for (int i = 0; i < IdleTo - 1; i++) nop();
        key(4'd2);
        check("late_key", 32'(bus.pin), 32'h0002);
        for (int i = 0; i < IdleTo - 1; i++) nop();
        check("restart_hold", 32'(bus.acc_num), 32'd7);
        nop();
        check("restart_expire", 32'(bus.acc_num), 32'd0);

        // Reset in AUTH, then a stray auth_done.
        enter_pin(4'd9, 16'h5678);
        do_reset();
        check("rst_auth", dut_outs(), {7'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd3});
        auth(1'b1);
        check("stray_auth", 32'(bus.session_active), 32'd0);

        // Reset in LOCK.
        for (int n = 0; n < 3; n++) begin
            if (n == 0) key(4'd1);
            for (int i = 0; i < 4; i++) key(4'd0);
            key(4'hA);
            auth(1'b0);
        end
        check("locked_again", 32'(bus.locked), 32'd1);
        nop(); nop();
        do_reset();
        check("rst_lock", dut_outs(), {7'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd3});

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
